iob_ram_dp_be_pipe: RTL and testbench
=====================================

Name: iob_ram_dp_be_pipe

Overview:
True dual-port RAM with byte enables, a column width set by a parameter, a configurable read pipeline and a selectable same-port read-during-write mode. It adds write-collision arbitration with a collision flag, and a built-in clear engine that zeroes the array after reset or on request. It is the parametrised successor of the basic dual-port byte-enable RAM and sits under the memory and register-file users in the same subsystem.

Parameters:
DATA_W, 32, word width; must be a multiple of COL_W
ADDR_W, 4, address width; depth is 2**ADDR_W
COL_W, 8, byte-enable column width; NCOL = DATA_W/COL_W
READ_LAT, 1, read latency in cycles; legal values are 1 and 2
WR_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (merged new word)

Ports:
clk  in  1  clock, rising edge
arst_n  in  1  asynchronous active-low reset
clr  in  1  one-cycle pulse; starts a zeroing sweep of the whole array
busy  out  1  high while the clear sweep runs; both ports are ignored
enA  in  1  port A access enable
weA  in  NCOL  port A per-column write enable
addrA  in  ADDR_W  port A address
dinA  in  DATA_W  port A write data
doutA  out  DATA_W  port A read data
rvalidA  out  1  doutA is valid this cycle
enB, weB, addrB, dinB, doutB, rvalidB  same as the port A signals, for port B
coll  out  1  write collision detected (registered, one-cycle pulse)

Behaviour:
- Reset, while arst_n is low: doutA = doutB = 0, rvalidA = rvalidB = 0, coll = 0, busy = 1. The FSM is forced to INIT with sweep counter 0. The array itself is not reset asynchronously.
- FSM states are INIT and IDLE.
- INIT:
  - Writes 0 to address cnt, then cnt increments.
  - After address 2**ADDR_W-1 is written, the FSM goes to IDLE and busy falls. busy is therefore high for exactly 2**ADDR_W cycles after reset is released.
  - enA and enB are ignored, and no rvalid is produced for them.
  - clr is ignored.
- IDLE:
  - clr = 1 goes to INIT with cnt = 0, and busy rises on the next cycle.
  - If clr and an access arrive in the same cycle, the access is performed and the sweep starts on the next cycle.
- A reset during INIT restarts the sweep from address 0.
- Accepted access: en = 1 in IDLE.
  - Each column c with we[c] = 1 writes din[c*COL_W +: COL_W] into mem[addr].
  - The read data for that access appears on dout READ_LAT cycles later, with rvalid high for exactly that one cycle. rvalid is issued for writes too.
- When there is no valid read, dout holds its last value.
- READ_LAT = 2 adds an output register stage. Both the data and rvalid are pipelined, so back-to-back accesses produce back-to-back rvalid.
- Same-port read-during-write:
  - WR_MODE = 0 returns the pre-write word.
  - WR_MODE = 1 returns the post-write merged word: written columns come from din, the other columns from old data.
- Cross-port read of an address the other port is writing in the same cycle always returns the old word.
- Collision: both ports accepted, same address, and (weA & weB) != 0.
  - Overlapping columns take port A's data.
  - Non-overlapping columns each take their own port's data.
  - coll = 1 on the following cycle only.
  - A same-address write with disjoint enables is not a collision.
- Address arithmetic has no wrap or bounds checking. The full 2**ADDR_W range is valid.

Decomposition:
- Package iob_ram_dp_be_pipe_pkg holds:
  - FSM state encoding: INIT = 1'b0, IDLE = 1'b1.
  - WR_MODE constants: RD_FIRST = 0, WR_FIRST = 1.
  - The NCOL derivation.
- One sub-module, iob_ram_rd_pipe, is instantiated once per port. It is parameterised by DATA_W and READ_LAT and carries the data and rvalid pipeline with its reset.
- The array, the collision merge and the FSM stay in the top level.

Test Plan:
All scenarios use DATA_W=32, ADDR_W=4, COL_W=8, READ_LAT=2, WR_MODE=0 unless stated otherwise.
1. Clear after reset and on request:
   - Release arst_n -> busy stays high for 16 cycles, then falls.
   - A then reads addr 5 -> doutA = 0x00000000 with rvalidA two cycles after the access.
2. Byte-enable merge:
   - A writes addr 3, 0x11223344, weA = 4'b1111.
   - A then writes 0xAABBCCDD with weA = 4'b0100.
   - B reads addr 3 -> doutB = 0x11BB3344.
3. Read-during-write modes: addr 2 holds 0x0000_0001, and A writes 0x0000_00FF with weA = 4'b0001.
   - WR_MODE=0 -> doutA = 0x00000001.
   - WR_MODE=1 -> doutA = 0x000000FF.
   - A following read returns 0x000000FF in both modes.
4. Collision at zeroed addr 7:
   - A writes 0xAAAAAAAA with weA = 4'b0011; B writes 0xBBBBBBBB with weB = 4'b0110, same cycle.
   - Read addr 7 -> 0x00BBAAAA; coll is high for exactly one cycle.
   - Repeat with weA = 4'b0001 and weB = 4'b0010 -> coll stays low.
5. Pipeline and latency:
   - A issues reads of addr 0..15 on 16 consecutive cycles.
   - 16 consecutive rvalidA pulses follow, starting 2 cycles later, in address order.
   - With READ_LAT=1 the first rvalidA arrives 1 cycle after the first read.
6. clr and reset during a sweep:
   - Pulse clr after writes -> all 16 addresses read back 0.
   - Assert arst_n low mid-sweep at cnt = 9 -> after release, busy stays high for a full 16 cycles again, and all outputs are 0 while reset is held.

Source files
------------

// File: rtl/iob_ram_dp_be_pipe_pkg.sv
// Shared types and constants for the dual-port byte-enable RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iob_ram_dp_be_pipe_pkg;

  // Clear-engine states: INIT sweeps zeros through the array, IDLE serves ports
  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  // Same-port read-during-write selection
  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  // Number of byte-enable columns in one word
  function automatic int calc_ncol(input int data_w, input int col_w);
    return data_w / col_w;
  endfunction

endpackage

// File: rtl/iob_ram_rd_pipe.sv
// Read-data / read-valid output pipeline for one RAM port.
// Latency: READ_LAT cycles (1 or 2) from in_vld to rvalid.
// Backpressure: none; dout holds its last value between valid reads.
module iob_ram_rd_pipe #(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid
);

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              s1_vld;
      logic [DATA_W-1:0] s1_dat;

      // Two register stages; each data stage loads only when its valid is set
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          s1_vld <= 1'b0;
          s1_dat <= '0;
          rvalid <= 1'b0;
          dout   <= '0;
        end else begin
          s1_vld <= in_vld;
          if (in_vld) s1_dat <= in_dat;
          rvalid <= s1_vld;
          if (s1_vld) dout <= s1_dat;
        end
      end
    end else begin : g_lat1
      // Single register stage; data loads only on a valid read
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          rvalid <= 1'b0;
          dout   <= '0;
        end else begin
          rvalid <= in_vld;
          if (in_vld) dout <= in_dat;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/iob_ram_dp_be_pipe.sv
// True dual-port byte-enable RAM with write-collision merge and a zeroing clear engine.
// Latency: READ_LAT cycles from accepted access to rvalid; the clear sweep takes 2**ADDR_W cycles.
// Backpressure: none; while busy both ports are ignored (no write, no rvalid).
module iob_ram_dp_be_pipe
  import iob_ram_dp_be_pipe_pkg::*;
#(
  parameter int  DATA_W   = 32,
  parameter int  ADDR_W   = 4,
  parameter int  COL_W    = 8,
  parameter int  READ_LAT = 1,
  parameter int  WR_MODE  = 0,
  localparam int NCOL     = calc_ncol(DATA_W, COL_W)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clr,
  output logic              busy,
  input  logic              enA,
  input  logic [NCOL-1:0]   weA,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [DATA_W-1:0] dinA,
  output logic [DATA_W-1:0] doutA,
  output logic              rvalidA,
  input  logic              enB,
  input  logic [NCOL-1:0]   weB,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] dinB,
  output logic [DATA_W-1:0] doutB,
  output logic              rvalidB,
  output logic              coll
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              acc_a, acc_b;
  logic [NCOL-1:0]   ovl;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;

  assign busy  = (state == INIT);
  assign acc_a = enA && (state == IDLE);
  assign acc_b = enB && (state == IDLE);
  // Columns both ports write to the same word this cycle; port A owns them
  assign ovl   = (acc_a && acc_b && (addrA == addrB)) ? (weA & weB) : '0;

  // Clear-engine state and sweep counter
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sweep every address once, then serve ports until clr restarts the sweep
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (&cnt) state_nxt = IDLE;
      end
      IDLE: begin
        if (clr) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // Read words: pre-write contents and per-port post-write merged words
  always_comb begin
    old_a = mem[addrA];
    old_b = mem[addrB];
    new_a = old_a;
    new_b = old_b;
    for (int c = 0; c < NCOL; c++) begin
      if (weA[c]) new_a[c*COL_W +: COL_W] = dinA[c*COL_W +: COL_W];
      if (weB[c]) new_b[c*COL_W +: COL_W] = ovl[c] ? dinA[c*COL_W +: COL_W]
                                                   : dinB[c*COL_W +: COL_W];
    end
  end

  assign rd_a = (WR_MODE == WR_FIRST) ? new_a : old_a;
  assign rd_b = (WR_MODE == WR_FIRST) ? new_b : old_b;

  // Array update: zero sweep in INIT, byte-enabled port writes in IDLE
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else begin
      for (int c = 0; c < NCOL; c++) begin
        if (acc_a && weA[c])
          mem[addrA][c*COL_W +: COL_W] <= dinA[c*COL_W +: COL_W];
        if (acc_b && weB[c] && !ovl[c])
          mem[addrB][c*COL_W +: COL_W] <= dinB[c*COL_W +: COL_W];
      end
    end
  end

  // One-cycle collision flag for overlapping same-address writes
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) coll <= 1'b0;
    else         coll <= |ovl;
  end

  iob_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_pipe_a (
    .clk    (clk),
    .arst_n (arst_n),
    .in_vld (acc_a),
    .in_dat (rd_a),
    .dout   (doutA),
    .rvalid (rvalidA)
  );

  iob_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_pipe_b (
    .clk    (clk),
    .arst_n (arst_n),
    .in_vld (acc_b),
    .in_dat (rd_b),
    .dout   (doutB),
    .rvalid (rvalidB)
  );

endmodule

// File: tb/tb_iob_ram_dp_be_pipe.sv
// Bench for iob_ram_dp_be_pipe: two instances share stimulus,
// one READ_LAT=2/read-first and one READ_LAT=1/write-first,
// with a queue scoreboard per output port.
module tb_iob_ram_dp_be_pipe;

  logic        clk = 1'b0;
  logic        arst_n, clr, enA, enB;
  logic [3:0]  weA, weB, addrA, addrB;
  logic [31:0] dinA, dinB;

  logic        busy0, busy1, coll0, coll1;
  logic        rvalidA0, rvalidB0, rvalidA1, rvalidB1;
  logic [31:0] doutA0, doutB0, doutA1, doutB1;

  always #5 clk = ~clk;

  iob_ram_dp_be_pipe #(.DATA_W(32), .ADDR_W(4), .COL_W(8), .READ_LAT(2), .WR_MODE(0)) u_l2 (
    .clk(clk), .arst_n(arst_n), .clr(clr), .busy(busy0),
    .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(doutA0), .rvalidA(rvalidA0),
    .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutB0), .rvalidB(rvalidB0),
    .coll(coll0));

  iob_ram_dp_be_pipe #(.DATA_W(32), .ADDR_W(4), .COL_W(8), .READ_LAT(1), .WR_MODE(1)) u_l1 (
    .clk(clk), .arst_n(arst_n), .clr(clr), .busy(busy1),
    .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(doutA1), .rvalidA(rvalidA1),
    .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutB1), .rvalidB(rvalidB1),
    .coll(coll1));

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    logic        ea;
    logic [3:0]  wa;
    logic [3:0]  aa;
    logic [31:0] da;
    logic        eb;
    logic [3:0]  wb;
    logic [3:0]  ab;
    logic [31:0] db;
    logic [31:0] xa0, xa1, xb0, xb1;
    bit          xc;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          sweep_left = 16;
  bit          mon_en = 1'b0;
  exp_t        q [4][$];
  bit          coll_at [int];
  logic [31:0] mem_m [16];
  logic [31:0] last [4];
  string       nm [4] = '{"doutA_lat2", "doutB_lat2", "doutA_lat1", "doutB_lat1"};
  vec_t        tbl [14];

  logic        rv_w [4];
  logic [31:0] dv_w [4];
  assign rv_w[0] = rvalidA0;
  assign rv_w[1] = rvalidB0;
  assign rv_w[2] = rvalidA1;
  assign rv_w[3] = rvalidB1;
  assign dv_w[0] = doutA0;
  assign dv_w[1] = doutB0;
  assign dv_w[2] = doutA1;
  assign dv_w[3] = doutB1;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: reset values, scoreboard pops, dout hold, collision pulse
  always @(negedge clk) begin
    if (mon_en) begin
      if (!arst_n) begin
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1 || coll0 !== 1'b0 || coll1 !== 1'b0 ||
            rvalidA0 !== 1'b0 || rvalidB0 !== 1'b0 || rvalidA1 !== 1'b0 || rvalidB1 !== 1'b0 ||
            doutA0 !== 32'h0 || doutB0 !== 32'h0 || doutA1 !== 32'h0 || doutB1 !== 32'h0) begin
          errors++;
          $display("FAIL reset_outputs cyc=%0d got busy=%b%b coll=%b%b rv=%b%b%b%b dout=%h/%h/%h/%h exp busy=11 rest 0",
                   cyc, busy0, busy1, coll0, coll1, rvalidA0, rvalidB0, rvalidA1, rvalidB1,
                   doutA0, doutB0, doutA1, doutB1);
        end
        for (int k = 0; k < 4; k++) last[k] = 32'h0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (rv_w[k]) begin
            if (q[k].size() > 0 && q[k][0].due == cyc) begin
              if (dv_w[k] !== q[k][0].dat) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", nm[k], cyc, dv_w[k], q[k][0].dat);
              end
              last[k] = q[k][0].dat;
              void'(q[k].pop_front());
            end else begin
              errors++;
              $display("FAIL %s_unexpected_rvalid cyc=%0d got=1 exp=0", nm[k], cyc);
              last[k] = dv_w[k];
            end
          end else if (q[k].size() > 0 && q[k][0].due <= cyc) begin
            errors++;
            $display("FAIL %s_missing_rvalid cyc=%0d got=0 exp=1 (data %h)", nm[k], cyc, q[k][0].dat);
            void'(q[k].pop_front());
          end else if (dv_w[k] !== last[k]) begin
            errors++;
            $display("FAIL %s_hold cyc=%0d got=%h exp=%h", nm[k], cyc, dv_w[k], last[k]);
          end
        end
        checks++;
        if (coll0 !== coll_at.exists(cyc) || coll1 !== coll_at.exists(cyc)) begin
          errors++;
          $display("FAIL coll cyc=%0d got=%b/%b exp=%b", cyc, coll0, coll1, coll_at.exists(cyc));
        end
      end
    end
  end

  function automatic vec_t mk(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                              input logic [31:0] da, input logic eb, input logic [3:0] wb,
                              input logic [3:0] ab, input logic [31:0] db);
    vec_t v;
    v = '{ea, wa, aa, da, eb, wb, ab, db, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    return v;
  endfunction

  // One clock of stimulus; called just after a falling edge, returns on the next one
  task automatic step(input vec_t v, input bit use_tbl, input logic clr_in);
    logic [31:0] old_a, old_b, wf_a, wf_b, ra0, ra1, rb0, rb1;
    bit          mc;
    exp_t        e;
    enA = v.ea; weA = v.wa; addrA = v.aa; dinA = v.da;
    enB = v.eb; weB = v.wb; addrB = v.ab; dinB = v.db;
    clr = clr_in;
    if (sweep_left == 0) begin
      old_a = mem_m[v.aa];
      old_b = mem_m[v.ab];
      for (int k = 0; k < 4; k++)
        if (v.eb && v.wb[k]) mem_m[v.ab][k*8 +: 8] = v.db[k*8 +: 8];
      for (int k = 0; k < 4; k++)
        if (v.ea && v.wa[k]) mem_m[v.aa][k*8 +: 8] = v.da[k*8 +: 8];
      wf_a = old_a;
      wf_b = old_b;
      for (int k = 0; k < 4; k++) begin
        if (v.wa[k]) wf_a[k*8 +: 8] = v.da[k*8 +: 8];
        if (v.wb[k]) wf_b[k*8 +: 8] = mem_m[v.ab][k*8 +: 8];
      end
      mc  = v.ea && v.eb && (v.aa == v.ab) && ((v.wa & v.wb) != 4'h0);
      ra0 = old_a; ra1 = wf_a; rb0 = old_b; rb1 = wf_b;
      if (use_tbl) begin
        ra0 = v.xa0; ra1 = v.xa1; rb0 = v.xb0; rb1 = v.xb1; mc = v.xc;
      end
      if (v.ea) begin
        e.due = cyc + 2; e.dat = ra0; q[0].push_back(e);
        e.due = cyc + 1; e.dat = ra1; q[2].push_back(e);
      end
      if (v.eb) begin
        e.due = cyc + 2; e.dat = rb0; q[1].push_back(e);
        e.due = cyc + 1; e.dat = rb1; q[3].push_back(e);
      end
      if (mc) coll_at[cyc + 1] = 1'b1;
    end
    @(posedge clk);
    if (sweep_left > 0) sweep_left--;
    else if (clr_in) begin
      sweep_left = 16;
      for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
    end
    @(negedge clk);
    checks++;
    if (busy0 !== (sweep_left != 0) || busy1 !== (sweep_left != 0)) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b/%b exp=%b", cyc, busy0, busy1, sweep_left != 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
  endtask

  task automatic release_rst();
    #1;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
    for (int k = 0; k < 4; k++) q[k].delete();
    coll_at.delete();
    sweep_left = 16;
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n = 1'b1; clr = 1'b0;
    enA = 1'b0; weA = 4'h0; addrA = 4'h0; dinA = 32'h0;
    enB = 1'b0; weB = 4'h0; addrB = 4'h0; dinB = 32'h0;

    //          ea  wa     aa     da            eb  wb     ab     db            xa0(l2)       xa1(l1)       xb0(l2)       xb1(l1)       coll
    tbl[0]  = '{1, 4'h0, 4'd5,  32'h0,        0, 4'h0, 4'd0,  32'h0,        32'h00000000, 32'h00000000, 32'h0,        32'h0,        0};
    tbl[1]  = '{1, 4'hF, 4'd3,  32'h11223344, 0, 4'h0, 4'd0,  32'h0,        32'h00000000, 32'h11223344, 32'h0,        32'h0,        0};
    tbl[2]  = '{1, 4'h4, 4'd3,  32'hAABBCCDD, 0, 4'h0, 4'd0,  32'h0,        32'h11223344, 32'h11BB3344, 32'h0,        32'h0,        0};
    tbl[3]  = '{0, 4'h0, 4'd0,  32'h0,        1, 4'h0, 4'd3,  32'h0,        32'h0,        32'h0,        32'h11BB3344, 32'h11BB3344, 0};
    tbl[4]  = '{1, 4'hF, 4'd2,  32'h00000001, 0, 4'h0, 4'd0,  32'h0,        32'h00000000, 32'h00000001, 32'h0,        32'h0,        0};
    tbl[5]  = '{1, 4'h1, 4'd2,  32'h000000FF, 0, 4'h0, 4'd0,  32'h0,        32'h00000001, 32'h000000FF, 32'h0,        32'h0,        0};
    tbl[6]  = '{1, 4'h0, 4'd2,  32'h0,        0, 4'h0, 4'd0,  32'h0,        32'h000000FF, 32'h000000FF, 32'h0,        32'h0,        0};
    tbl[7]  = '{1, 4'h3, 4'd7,  32'hAAAAAAAA, 1, 4'h6, 4'd7,  32'hBBBBBBBB, 32'h00000000, 32'h0000AAAA, 32'h00000000, 32'h00BBAA00, 1};
    tbl[8]  = '{1, 4'h0, 4'd7,  32'h0,        1, 4'h0, 4'd7,  32'h0,        32'h00BBAAAA, 32'h00BBAAAA, 32'h00BBAAAA, 32'h00BBAAAA, 0};
    tbl[9]  = '{1, 4'h1, 4'd7,  32'h11111111, 1, 4'h2, 4'd7,  32'h22222222, 32'h00BBAAAA, 32'h00BBAA11, 32'h00BBAAAA, 32'h00BB22AA, 0};
    tbl[10] = '{1, 4'h0, 4'd7,  32'h0,        0, 4'h0, 4'd0,  32'h0,        32'h00BB2211, 32'h00BB2211, 32'h0,        32'h0,        0};
    tbl[11] = '{1, 4'hF, 4'd4,  32'hDEADBEEF, 1, 4'h0, 4'd4,  32'h0,        32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 0};
    tbl[12] = '{1, 4'hF, 4'd15, 32'h12345678, 1, 4'h0, 4'd4,  32'h0,        32'h00000000, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 0};
    tbl[13] = '{1, 4'h0, 4'd15, 32'h0,        1, 4'h0, 4'd0,  32'h0,        32'h12345678, 32'h12345678, 32'h00000000, 32'h00000000, 0};

    // Power-on reset, then the post-reset sweep with port A requests that must be ignored
    #1 arst_n = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    release_rst();
    for (int i = 0; i < 16; i++) step(mk(1, 4'hF, 4'(i), 32'hCAFE0000, 1, 4'h0, 4'(i), 32'h0), 1'b0, 1'b1);

    // Directed vectors: zeroed read, byte merge, read-during-write, collisions, cross-port, top address
    for (int i = 0; i < 14; i++) step(tbl[i], 1'b1, 1'b0);
    idle(3);

    // Back-to-back pipeline: fill every address, then read 0..15 on consecutive cycles
    for (int i = 0; i < 16; i++) step(mk(1, 4'hF, 4'(i), $urandom, 0, 0, 0, 0), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(mk(1, 4'h0, 4'(i), 32'h0, 1, 4'h0, 4'(15 - i), 32'h0), 1'b0, 1'b0);
    idle(3);

    // Random dual-port traffic on a narrow address window to provoke collisions
    for (int i = 0; i < 200; i++)
      step(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(4, 7)), $urandom,
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(4, 7)), $urandom),
           1'b0, 1'b0);
    idle(3);

    // clr together with an access; ports and clr ignored during the sweep; array reads back zero
    step(mk(1, 4'hF, 4'd9, 32'h99999999, 1, 4'h0, 4'd9, 32'h0), 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      step(mk(1, 4'hF, 4'(i), $urandom, 1, 4'hF, 4'(15 - i), $urandom), 1'b0, 1'(i % 2));
    for (int i = 0; i < 16; i++) step(mk(1, 4'h0, 4'(i), 32'h0, 0, 0, 0, 0), 1'b0, 1'b0);
    idle(3);

    // Reset in the middle of a sweep restarts it from address 0
    for (int i = 0; i < 16; i++) step(mk(1, 4'hF, 4'(i), $urandom, 0, 0, 0, 0), 1'b0, 1'b0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    idle(9);
    #2 arst_n = 1'b0;
    for (int k = 0; k < 4; k++) q[k].delete();
    repeat (3) @(negedge clk);
    release_rst();
    idle(16);
    for (int i = 0; i < 16; i++) step(mk(0, 0, 0, 0, 1, 4'h0, 4'(i), 32'h0), 1'b0, 1'b0);
    idle(4);

    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q[k].size() != 0) begin
        errors++;
        $display("FAIL %s_drain got=%0d pending exp=0", nm[k], q[k].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
